axi_rom_rd_slave: RTL
=====================

Name: axi_rom_rd_slave

Overview:
- AXI3 read-only responder: the slave end of the instruction-fetch AXI read channel driven by the icache refill and pre-fetch masters.
- Serves single and burst reads from an internal word-addressed memory.
- The memory is preloaded through a simple write port.
- Used as the instruction-memory model in IF-stage cache/pre-fetch benches and as a BRAM-backed boot ROM on FPGA.

Parameters:
ID_W, 4, width of arid/rid
DEPTH_LOG2, 12, memory depth in 32-bit words (2^DEPTH_LOG2)
RD_LATENCY, 2, cycles from AR handshake to first rvalid (0 allowed)

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
arid  in  ID_W  read ID
araddr  in  32  byte address of first beat
arlen  in  4  beats minus 1
arsize  in  3  bytes per beat, log2
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
arvalid  in  1  address valid
arready  out  1  address accepted
rid  out  ID_W  echo of captured arid
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat
rvalid  out  1  data valid
rready  in  1  master accepts beat
mem_we  in  1  preload write enable
mem_waddr  in  DEPTH_LOG2  preload word index
mem_wdata  in  32  preload data

Behaviour:
- Reset (async assert, sync deassert-safe): state IDLE; arready=1, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0. Memory contents are not cleared.
- Reset asserted mid-burst aborts the burst. There is no partial completion.
- FSM states: IDLE, WAIT, BURST.
- IDLE: arready=1. On arvalid&&arready, capture id, addr, len, size, burst; load beat counter=0.
  - Go to WAIT with lat_cnt=RD_LATENCY-1 if RD_LATENCY>0.
  - Go directly to BURST if RD_LATENCY=0.
- WAIT: arready=0. Decrement lat_cnt; at 0, go to BURST.
- BURST: arready=0. rvalid=1 with rdata, rresp and rlast registered on entry and after each beat handshake.
  - rvalid/rdata/rresp/rlast/rid are held stable while rready=0.
  - On rvalid&&rready with rlast=1: go to IDLE. rvalid=0 and arready=1 on the next cycle.
  - One transaction in flight only. No outstanding AR acceptance.
- Latency: first rvalid occurs RD_LATENCY+1 cycles after the AR handshake edge. Back-to-back beats are possible with rready held high (1 beat/cycle).
- Beat address: word index = addr[DEPTH_LOG2+1:2]. Upper address bits are ignored (aliasing).
  - FIXED: every beat uses the start address.
  - INCR: addr + 4*beat. The word index wraps modulo 2^DEPTH_LOG2.
  - WRAP: boundary = (arlen+1)*4 bytes. Beat address = (start & ~(boundary-1)) | ((start + 4*beat) & (boundary-1)).
- Errors:
  - Condition: arsize!=3'b010, or arburst==2'b11, or WRAP with arlen not in {1,3,7,15}.
  - Response: the full arlen+1 beats are returned with rresp=2'b10 and rdata=0. rlast is still correct.
- rid equals the captured arid on every beat. rlast=1 exactly when beat==arlen.
- Preload: a mem_we write lands at the aclk edge.
  - rdata is sampled from the array when a beat is loaded, using pre-edge contents.
  - A write to a word after its beat is loaded is not visible in that beat.
  - Writes are permitted in any state.

Decomposition:
- Shared axi_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP
  - resp encodings RESP_OKAY/SLVERR
  - rd_state_t enum {IDLE, WAIT, BURST}
  - SIZE_4B constant
- One natural sub-module: rom_mem. It is a 2^DEPTH_LOG2 x 32 single-write, single-read array that infers BRAM, with a read address taken from the FSM's next-beat address.

Test Plan:
- Single read (arlen=0, INCR, araddr=0x1FC0_0010, word 4 preloaded 0x2400_0001, RD_LATENCY=2) -> rvalid 3 cycles after AR handshake, rdata=0x2400_0001, rresp=00, rlast=1, arready high again next cycle.
- 8-beat INCR from 0x0000_0020 with words 8..15 = 0x100..0x107, rready toggling 1,0,1,... -> beats 0x100..0x107 in order, data stable across rready=0, rlast only on the 8th beat.
- WRAP arlen=7 at 0x0000_0038 (word 14) -> word order 14,15,8,9,10,11,12,13. Then arlen=5 WRAP -> six beats with rresp=10, rdata=0, rlast on the 6th.
- arsize=3'b001 single read -> one beat, rresp=10. Next valid read returns OKAY, proving recovery.
- Deassert aresetn during beat 3 of an 8-beat burst -> rvalid=0 and arready=1 asynchronously. After release, a new read with arid=0x5 returns rid=0x5 and correct data.
- RD_LATENCY=0 build, 16-beat INCR with rready held high from 0x3FF8 (DEPTH_LOG2=12) -> first rvalid 1 cycle after handshake, 16 consecutive beats, word index wraps 4094,4095,0,1,...

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-channel definitions used by the ROM read responder.
//   - burst / response / size encodings
//   - rd_state_t : read FSM state encoding
//   - ar_is_err  : classifies an AR request the responder cannot serve
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} rd_state_t;

    // Only 32-bit beats are served. A reserved burst type is an error.
    // A WRAP burst must be 2, 4, 8 or 16 beats long, so len must be 2^n-1 with len != 0.
    function automatic logic ar_is_err(input logic [3:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len != 4'd0) && ((len & (len + 4'd1)) == 4'd0);
        return (size != SIZE_4B) || (burst == 2'b11) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/rom_mem.sv
// 2^DEPTH_LOG2 x 32 word array with one write port and one registered read port.
// The structure is kept simple so that it maps onto block RAM.
// Ports:
//   clk          clock
//   we/waddr/wdata  preload write, lands at the clock edge
//   re/raddr     read enable and word index; rdata updates on the edge when re=1
//   rdata        registered read data (read-before-write on address collision)
module rom_mem #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // The write and the read sit in the same process with non-blocking
    // assignments. A beat loaded in the same cycle as a write to its word
    // therefore sees the old contents.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_rom_rd_slave.sv
// AXI3 read-only responder backed by a preloadable word memory.
// It accepts one AR at a time. After RD_LATENCY wait cycles it streams arlen+1 beats.
// Unsupported requests get SLVERR beats carrying zero data.
// Ports:
//   aclk, aresetn                     clock, async active-low reset
//   arid/araddr/arlen/arsize/arburst  read address channel payload
//   arvalid/arready                   read address handshake
//   rid/rdata/rresp/rlast             read data channel payload
//   rvalid/rready                     read data handshake
//   mem_we/mem_waddr/mem_wdata        memory preload port
module axi_rom_rd_slave
    import axi_pkg::*;
#(
    parameter int ID_W       = 4,
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ID_W-1:0]       arid,
    input  logic [31:0]           araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_W-1:0]       rid,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic                  mem_we,
    input  logic [DEPTH_LOG2-1:0] mem_waddr,
    input  logic [31:0]           mem_wdata
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

    rd_state_t             state, state_nxt;
    logic [ID_W-1:0]       id_q;
    logic [DEPTH_LOG2-1:0] start_q;
    logic [3:0]            len_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic [3:0]            beat_cnt;
    logic [LAT_W-1:0]      lat_cnt;
    logic                  rvalid_q, rlast_q;
    logic [1:0]            rresp_q;
    logic [31:0]           mem_q;
    logic                  ar_hs, load, last_hs;
    logic [DEPTH_LOG2-1:0] beat_addr, wrap_mask;

    // Address bits outside the word index are ignored, so upper addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr[31:DEPTH_LOG2+2], araddr[1:0]};

    // ---- FSM: state register ----
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (arvalid) state_nxt = (RD_LATENCY == 0) ? BURST : WAIT;
            WAIT:  if (lat_cnt == '0) state_nxt = BURST;
            BURST: if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    // A beat is (re)loaded on BURST entry, when no beat is presented yet,
    // and after every non-final handshake. This allows one beat per cycle.
    always_comb begin
        arready = (state == IDLE);
        ar_hs   = arready && arvalid;
        last_hs = rvalid_q && rready && rlast_q;
        load    = (state == BURST) && (!rvalid_q || (rready && !rlast_q));
    end

    // Word-granular beat address. The WRAP mask equals len because legal WRAP
    // lengths are 2^n-1. This matches the byte-boundary formula shifted right by 2.
    always_comb begin
        wrap_mask = DEPTH_LOG2'(len_q);
        beat_addr = start_q;
        case (burst_q)
            BURST_INCR: beat_addr = start_q + DEPTH_LOG2'(beat_cnt);
            BURST_WRAP: beat_addr = (start_q & ~wrap_mask) |
                                    ((start_q + DEPTH_LOG2'(beat_cnt)) & wrap_mask);
            default:    beat_addr = start_q;
        endcase
    end

    // ---- request capture and beat sequencing ----
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            id_q     <= '0;
            start_q  <= '0;
            len_q    <= '0;
            burst_q  <= BURST_FIXED;
            err_q    <= 1'b0;
            beat_cnt <= '0;
            lat_cnt  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                id_q     <= arid;
                start_q  <= araddr[DEPTH_LOG2+1:2];
                len_q    <= arlen;
                burst_q  <= arburst;
                err_q    <= ar_is_err(arlen, arsize, arburst);
                beat_cnt <= '0;
                lat_cnt  <= LAT_INIT;
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt  <= lat_cnt - 1'b1;
            end

            if (load) begin
                rvalid_q <= 1'b1;
                rlast_q  <= (beat_cnt == len_q);
                rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
                beat_cnt <= beat_cnt + 4'd1;
            end else if (last_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    rom_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk   (aclk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (load),
        .raddr (beat_addr),
        .rdata (mem_q)
    );

    // The memory output register has no reset, so that it still maps onto block RAM.
    // rdata is therefore gated to zero when no beat is presented and on error beats.
    assign rdata  = (rvalid_q && !err_q) ? mem_q : 32'h0;
    assign rid    = id_q;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;
    assign rvalid = rvalid_q;

endmodule
